// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : fetch_ctrl_if
// Description : Request/status bundle between the fetch sequencer and the
//               surrounding decoder, data memory and fetch stage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  // Requests and decode information into the sequencer
  logic             start_req;
  logic             halt_instr;
  logic             branch_taken;
  logic [7:0]       branch_offset;
  logic             mem_busy;

  // Fetch-stage controls and status out of the sequencer
  logic             if_start;
  logic             if_halt;
  logic             if_branch;
  logic [7:0]       if_target;
  logic             ack;
  logic             error;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] stall_count;

  // Side that issues requests and consumes the fetch controls
  modport master (
    output start_req, halt_instr, branch_taken, branch_offset, mem_busy,
    input  if_start, if_halt, if_branch, if_target, ack, error,
           cycle_count, stall_count
  );

  // The sequencer itself
  modport slave (
    input  start_req, halt_instr, branch_taken, branch_offset, mem_busy,
    output if_start, if_halt, if_branch, if_target, ack, error,
           cycle_count, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : fetch_ctrl
// Description : Instruction-fetch PC sequencer. Generates start/halt/branch
//               controls for the fetch stage, reports completion, watches for
//               stuck data memory and keeps saturating cycle/stall counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int MAX_STALL = 255,
  parameter int CNT_W     = 16
) (
  input  wire logic   CLK,
  input  wire logic   RST_N,
  fetch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Last watchdog value before a further busy cycle trips it
  localparam logic [15:0] C_WD_LAST = 16'(MAX_STALL - 1);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_wd;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_stall_count;
  logic             r_ack;
  logic             r_error;

  logic             w_if_start;
  logic             w_if_halt;
  logic             w_if_branch;
  logic             w_clear;
  logic             w_count_cycle;
  logic             w_count_stall;
  logic             w_wd_inc;
  logic             w_wd_clr;
  logic             w_done;
  logic             w_trip;

  // State register; reset lands in IDLE so the fetch controls are at their
  // reset values as soon as RST_N falls
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus Mealy fetch controls; restart beats halt beats busy
  always_comb begin
    w_next        = r_state;
    w_if_start    = 1'b0;
    w_if_halt     = 1'b1;
    w_if_branch   = 1'b0;
    w_clear       = 1'b0;
    w_count_cycle = 1'b0;
    w_count_stall = 1'b0;
    w_wd_inc      = 1'b0;
    w_wd_clr      = 1'b0;
    w_done        = 1'b0;
    w_trip        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_req) begin
          w_next  = S_INIT;
          w_clear = 1'b1;
        end
      end
      S_INIT: begin
        w_if_start = 1'b1;
        w_if_halt  = 1'b0;
        w_clear    = 1'b1;
        w_next     = S_RUN;
      end
      S_RUN, S_STALL: begin
        w_count_cycle = 1'b1;
        if (bus.start_req) begin
          w_next  = S_INIT;
          w_clear = 1'b1;
        end else if (bus.halt_instr) begin
          w_next = S_DONE;
          w_done = 1'b1;
        end else if (bus.mem_busy) begin
          w_count_stall = 1'b1;
          if ((r_state == S_STALL) && (r_wd >= C_WD_LAST)) begin
            w_next = S_DONE;
            w_done = 1'b1;
            w_trip = 1'b1;
          end else begin
            w_next   = S_STALL;
            w_wd_inc = 1'b1;
          end
        end else begin
          w_if_halt   = 1'b0;
          w_if_branch = bus.branch_taken;
          w_wd_clr    = 1'b1;
          w_next      = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.start_req) begin
          w_next  = S_INIT;
          w_clear = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Status registers: clearing on the way into INIT, otherwise saturating
  // counters, a sticky completion flag and a sticky watchdog error
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cycle_count <= '0;
      r_stall_count <= '0;
      r_wd          <= '0;
      r_ack         <= 1'b0;
      r_error       <= 1'b0;
    end else if (w_clear) begin
      r_cycle_count <= '0;
      r_stall_count <= '0;
      r_wd          <= '0;
      r_ack         <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      if (w_count_cycle && (r_cycle_count != {CNT_W{1'b1}})) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      if (w_count_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_wd_clr) begin
        r_wd <= '0;
      end else if (w_wd_inc && (r_wd != 16'hFFFF)) begin
        r_wd <= r_wd + 16'd1;
      end
      if (w_done) begin
        r_ack <= 1'b1;
      end
      if (w_trip) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.if_start    = w_if_start;
  assign bus.if_halt     = w_if_halt;
  assign bus.if_branch   = w_if_branch;
  assign bus.if_target   = w_if_branch ? bus.branch_offset : 8'h00;
  assign bus.ack         = r_ack;
  assign bus.error       = r_error;
  assign bus.cycle_count = r_cycle_count;
  assign bus.stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl: directed scenarios plus a
//               randomized run against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int MAX_STALL = 4;
  localparam int CNT_W     = 4;
  localparam int CMAX      = (1 << CNT_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_INIT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_STALL = 3;
  localparam int M_DONE  = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fetch_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: program phase, status flags, counters, busy run length
  int   m_mode;
  int   m_cyc;
  int   m_stl;
  int   m_busy;
  bit   m_ack;
  bit   m_err;
  logic e_start;
  logic e_halt;
  logic e_branch;
  logic [7:0] e_target;

  function void model_reset();
    m_mode = M_IDLE;
    m_cyc  = 0;
    m_stl  = 0;
    m_busy = 0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
  endfunction

  function void model_restart();
    model_reset();
    m_mode = M_INIT;
  endfunction

  // Expected fetch controls for the current phase and inputs
  function void model_comb();
    e_start  = 1'b0;
    e_halt   = 1'b1;
    e_branch = 1'b0;
    if (m_mode == M_INIT) begin
      e_start = 1'b1;
      e_halt  = 1'b0;
    end else if (m_mode == M_RUN || m_mode == M_STALL) begin
      e_halt   = bus.start_req | bus.halt_instr | bus.mem_busy;
      e_branch = !e_halt && bus.branch_taken;
    end
    e_target = e_branch ? bus.branch_offset : 8'h00;
  endfunction

  // Advance the model by one clock using the inputs held this cycle
  function void model_seq();
    case (m_mode)
      M_IDLE, M_DONE: if (bus.start_req) model_restart();
      M_INIT:         m_mode = M_RUN;
      default: begin
        if (bus.start_req) begin
          model_restart();
        end else begin
          if (m_cyc < CMAX) m_cyc++;
          if (bus.halt_instr) begin
            m_ack  = 1'b1;
            m_mode = M_DONE;
          end else if (bus.mem_busy) begin
            if (m_stl < CMAX) m_stl++;
            m_busy++;
            if (m_mode == M_STALL && m_busy >= MAX_STALL) begin
              m_ack  = 1'b1;
              m_err  = 1'b1;
              m_mode = M_DONE;
            end else begin
              m_mode = M_STALL;
            end
          end else begin
            m_busy = 0;
            m_mode = M_RUN;
          end
        end
      end
    endcase
  endfunction

  // Apply inputs one time unit after the edge, settle, then refresh expectations
  task automatic drive(input bit sr, input bit hi, input bit bt,
                       input logic [7:0] off, input bit mb);
    bus.start_req     = sr;
    bus.halt_instr    = hi;
    bus.branch_taken  = bt;
    bus.branch_offset = off;
    bus.mem_busy      = mb;
    #2;
    model_comb();
  endtask

  task automatic tick();
    @(posedge CLK);
    model_seq();
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.if_start, bus.if_halt, bus.if_branch, bus.if_target, bus.ack, bus.error} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got start=%b halt=%b br=%b tgt=%h ack=%b err=%b, want 0 1 0 00 0 0",
               bus.if_start, bus.if_halt, bus.if_branch, bus.if_target, bus.ack, bus.error);
    end
    n_checks++;
    if ({bus.cycle_count, bus.stall_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got cyc=%0d stl=%0d, want 0 0", bus.cycle_count, bus.stall_count);
    end
  endtask

  task automatic test_start();
    for (int c = 0; c < 10; c++) begin
      drive(c == 2, 1'b0, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (bus.if_start !== (c == 3)) begin
        n_fail++;
        $display("FAIL start_pulse c%0d: got %b want %b", c, bus.if_start, (c == 3));
      end
      if (c >= 4) begin
        n_checks++;
        if (bus.if_halt !== 1'b0) begin
          n_fail++;
          $display("FAIL start_run_halt c%0d: got %b want 0", c, bus.if_halt);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (bus.cycle_count !== CNT_W'(5)) begin
          n_fail++;
          $display("FAIL start_cycle_count: got %0d want 5", bus.cycle_count);
        end
      end
      tick();
    end
  endtask

  task automatic test_branch();
    drive(1'b0, 1'b0, 1'b1, 8'hFC, 1'b0);
    n_checks++;
    if ({bus.if_branch, bus.if_target} !== {1'b1, 8'hFC}) begin
      n_fail++;
      $display("FAIL branch_taken: got br=%b tgt=%h want 1 fc", bus.if_branch, bus.if_target);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
    n_checks++;
    if ({bus.if_branch, bus.if_target} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL branch_after: got br=%b tgt=%h want 0 00", bus.if_branch, bus.if_target);
    end
    tick();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'h10, 1'b1);
      n_checks++;
      if ({bus.if_halt, bus.if_branch} !== 2'b10) begin
        n_fail++;
        $display("FAIL stall_hold %0d: got halt=%b br=%b want 1 0", i, bus.if_halt, bus.if_branch);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
    n_checks++;
    if ({bus.if_halt, bus.if_branch, bus.if_target} !== {1'b0, 1'b1, 8'h10}) begin
      n_fail++;
      $display("FAIL stall_release: got halt=%b br=%b tgt=%h want 0 1 10", bus.if_halt, bus.if_branch, bus.if_target);
    end
    n_checks++;
    if ({bus.stall_count, bus.error} !== {CNT_W'(3), 1'b0}) begin
      n_fail++;
      $display("FAIL stall_count: got stl=%0d err=%b want 3 0", bus.stall_count, bus.error);
    end
    tick();
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < MAX_STALL; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus.ack !== 1'b0) begin
        n_fail++;
        $display("FAIL wd_early_ack %0d: got %b want 0", i, bus.ack);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({bus.ack, bus.error, bus.if_halt} !== 3'b111) begin
      n_fail++;
      $display("FAIL wd_trip: got ack=%b err=%b halt=%b want 1 1 1", bus.ack, bus.error, bus.if_halt);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if ({bus.if_start, bus.ack, bus.error} !== 3'b100) begin
      n_fail++;
      $display("FAIL wd_restart: got start=%b ack=%b err=%b want 1 0 0", bus.if_start, bus.ack, bus.error);
    end
    tick();
  endtask

  task automatic test_halt_branch();
    int snap_cyc;
    int snap_stl;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    n_checks++;
    if ({bus.if_halt, bus.if_branch, bus.if_target} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL halt_over_branch: got halt=%b br=%b tgt=%h want 1 0 00", bus.if_halt, bus.if_branch, bus.if_target);
    end
    tick();
    snap_cyc = m_cyc;
    snap_stl = m_stl;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'($urandom), 1'($urandom));
      n_checks++;
      if ({bus.ack, bus.cycle_count, bus.stall_count} !== {1'b1, CNT_W'(snap_cyc), CNT_W'(snap_stl)}) begin
        n_fail++;
        $display("FAIL halt_frozen %0d: got ack=%b cyc=%0d stl=%0d want 1 %0d %0d",
                 i, bus.ack, bus.cycle_count, bus.stall_count, snap_cyc, snap_stl);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
  endtask

  task automatic test_restart();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 8'h44, 1'b1);
    n_checks++;
    if ({bus.if_halt, bus.if_branch} !== 2'b10) begin
      n_fail++;
      $display("FAIL restart_ctrl: got halt=%b br=%b want 1 0", bus.if_halt, bus.if_branch);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if ({bus.if_start, bus.cycle_count, bus.stall_count} !== {1'b1, CNT_W'(0), CNT_W'(0)}) begin
      n_fail++;
      $display("FAIL restart_init: got start=%b cyc=%0d stl=%0d want 1 0 0", bus.if_start, bus.cycle_count, bus.stall_count);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 8'h21, 1'b1);
    RST_N = 1'b0;
    #1;
    n_checks++;
    if ({bus.if_start, bus.if_halt, bus.if_branch, bus.if_target, bus.ack, bus.error,
         bus.cycle_count, bus.stall_count} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, CNT_W'(0), CNT_W'(0)}) begin
      n_fail++;
      $display("FAIL async_reset: got start=%b halt=%b br=%b tgt=%h ack=%b err=%b cyc=%0d stl=%0d want 0 1 0 00 0 0 0 0",
               bus.if_start, bus.if_halt, bus.if_branch, bus.if_target, bus.ack, bus.error,
               bus.cycle_count, bus.stall_count);
    end
    model_reset();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < CMAX + 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (bus.cycle_count !== CNT_W'(CMAX)) begin
      n_fail++;
      $display("FAIL sat_cycle: got %0d want %0d", bus.cycle_count, CMAX);
    end
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if ({bus.stall_count, bus.error} !== {CNT_W'(CMAX), 1'b0}) begin
      n_fail++;
      $display("FAIL sat_stall: got stl=%0d err=%b want %0d 0", bus.stall_count, bus.error, CMAX);
    end
    tick();
  endtask

  task automatic test_random();
    int burst;
    bit mb;
    burst = 0;
    for (int i = 0; i < 400; i++) begin
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(2, 6);
      mb = (burst > 0) || ($urandom_range(0, 3) == 0);
      if (burst > 0) burst--;
      drive(($urandom_range(0, 39) == 0) || (m_mode == M_DONE && $urandom_range(0, 3) == 0),
            ($urandom_range(0, 24) == 0), 1'($urandom), 8'($urandom), mb);
      n_checks++;
      if ({bus.if_start, bus.if_halt, bus.if_branch, bus.if_target, bus.ack, bus.error,
           bus.cycle_count, bus.stall_count} !==
          {e_start, e_halt, e_branch, e_target, m_ack, m_err, CNT_W'(m_cyc), CNT_W'(m_stl)}) begin
        n_fail++;
        $display("FAIL random %0d: got st=%b h=%b b=%b t=%h a=%b e=%b c=%0d s=%0d want st=%b h=%b b=%b t=%h a=%b e=%b c=%0d s=%0d",
                 i, bus.if_start, bus.if_halt, bus.if_branch, bus.if_target, bus.ack, bus.error,
                 bus.cycle_count, bus.stall_count, e_start, e_halt, e_branch, e_target,
                 m_ack, m_err, m_cyc, m_stl);
      end
      tick();
    end
  endtask

  initial begin
    bus.start_req     = 1'b0;
    bus.halt_instr    = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 8'h00;
    bus.mem_busy      = 1'b0;
    model_reset();
    #3;
    test_reset();
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    test_start();
    test_branch();
    test_stall();
    test_watchdog();
    test_halt_branch();
    test_restart();
    test_async_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch program counter. It turns a bench start request, decoded halt/branch information and a data-memory busy flag into the per-cycle `start`/`Halt`/`Branch`/`Target` controls of the fetch stage. It reports program completion with `ack`, flags stuck memory with a stall watchdog, and keeps cycle and stall statistics. It sits between the decoder/ALU/data-memory and the fetch stage, in the top-level processor.

## Interface
- `MAX_STALL`, 255: max consecutive memory-stall cycles before the watchdog trips (1..65535)
- `CNT_W`, 16: width of statistics counters
- `CLK` in 1: clock, rising edge
- `RST_N` in 1: asynchronous, active-low reset
- `start_req` in 1: request to (re)start the program from PC 0
- `halt_instr` in 1: current instruction is HALT
- `branch_taken` in 1: current instruction is a taken branch
- `branch_offset` in 8: signed PC-relative offset for the taken branch
- `mem_busy` in 1: data memory has not finished the current access
- `if_start` out 1: to fetch `start`; forces PC to 0 at the next edge
- `if_halt` out 1: to fetch `Halt`; holds PC
- `if_branch` out 1: to fetch `Branch`
- `if_target` out 8: to fetch `Target`
- `ack` out 1: program finished (normal or watchdog)
- `error` out 1: watchdog tripped
- `cycle_count` out CNT_W: cycles spent in RUN+STALL, saturating
- `stall_count` out CNT_W: cycles frozen by `mem_busy`, saturating

## Operation
- States: IDLE, INIT, RUN, STALL, DONE.
- Reset (async, `RST_N`=0) enters IDLE. It clears `ack`, `error`, both counters and the watchdog counter.
- IDLE:
  - Outputs: `if_halt`=1, all other fetch controls 0.
  - `start_req` → INIT.
- INIT:
  - Outputs: `if_start`=1, `if_halt`=0, `if_branch`=0.
  - Clears `ack`, `error`, counters and watchdog.
  - Always → RUN next cycle.
- RUN and STALL share the fetch-control equations (Mealy, combinational from inputs). Priority: `halt_instr` > `mem_busy` > `branch_taken`.
  - `halt_instr`=1: `if_halt`=1, `if_branch`=0; next state DONE.
  - else `mem_busy`=1: `if_halt`=1, `if_branch`=0; next state STALL; watchdog +1; `stall_count` +1.
  - else: `if_halt`=0, `if_branch`=`branch_taken`; next state RUN; watchdog cleared.
- `if_target` = `branch_offset` when `if_branch`=1, else 8'h00.
- Watchdog: in STALL with `mem_busy`=1 and watchdog = MAX_STALL-1 → DONE with `error` set.
- DONE:
  - Outputs: `if_halt`=1, `ack`=1, `error` held.
  - `start_req` → INIT.
- `start_req` in RUN/STALL is a restart: → INIT, overriding all other inputs that cycle. Outputs that cycle are `if_halt`=1 and `if_branch`=0.
- `start_req` in INIT is ignored.
- `cycle_count` increments every cycle in RUN or STALL. Both counters saturate at all-ones and never wrap.

## Timing
- All state, `ack`, `error` and counters are registered.
- Fetch controls are combinational from state and inputs, so a branch or halt affects PC at the same edge as its decode cycle.
- Reset values: `if_start`=0, `if_halt`=1, `if_branch`=0, `if_target`=0, `ack`=0, `error`=0, counts 0.
- Start latency, with `start_req` high in cycle n (IDLE):
  - n+1 is INIT with `if_start`=1.
  - PC=0 after edge n+1.
  - n+2 executes PC 0 in RUN.
- Halt: `halt_instr` in cycle k freezes PC at edge k. `ack`=1 from cycle k+1 until the INIT cycle after the next `start_req`.
- Stall: PC is held every cycle `mem_busy`=1. The first cycle with `mem_busy`=0 applies that instruction's branch/increment.
- Reset mid-operation: outputs return to reset values immediately (async), with no wait for an edge.

## Test plan
- Reset, then `start_req` pulse at cycle 2, then idle inputs:
  - `if_start`=1 only in cycle 3.
  - `if_halt`=0 from cycle 4.
  - `cycle_count`=5 after 5 RUN cycles.
- RUN with `branch_taken`=1, `branch_offset`=8'hFC for one cycle → `if_branch`=1, `if_target`=8'hFC that cycle; 0/0 the next cycle.
- `mem_busy` high 3 cycles with `branch_taken`=1 throughout:
  - `if_halt`=1 and `if_branch`=0 for those 3 cycles, `if_branch`=1 in cycle 4.
  - `stall_count`=3, `error`=0.
- MAX_STALL=4, `mem_busy` held high:
  - DONE after 4 stall cycles; `ack`=1, `error`=1.
  - A following `start_req` clears both in INIT.
- `halt_instr` and `branch_taken` high together in cycle k:
  - `if_branch`=0, `if_halt`=1.
  - `ack`=1 from k+1; counters frozen.
- `start_req` asserted mid-RUN → INIT next cycle with counters cleared. Separately, `RST_N` dropped mid-STALL → `if_halt`=1, `ack`=0, counts 0 without a clock edge.
